// File: rtl/comparator_multicycle.sv
// comparator_multicycle
//   Multi-cycle magnitude comparator for the ALU/branch path. A - B is formed
//   CHUNK bits per cycle, LSB first, through one narrow adder, and the result
//   is reported as lt/eq/le flags for either a signed or an unsigned compare.
//   Operands enter and flags leave through valid/ready handshakes. Only one
//   transaction is in flight at a time.
//
//   Optional feature macro: COMPARATOR_MINMAX_EN
//     When defined, the min_out/max_out ports are added. They carry the smaller
//     and larger operand and are registered together with the flags.
//
// Parameters
//   N      operand width; must be a multiple of CHUNK
//   CHUNK  bits subtracted per cycle (NCHUNK = N/CHUNK RUN cycles)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   i_valid    operands valid           i_ready   block can accept operands
//   a, b       operands (N bits)        is_signed 1: two's-complement compare
//   o_valid    result flags valid       o_ready   consumer accepts the result
//   lt, eq, le a<b, a==b, a<=b (registered; hold their value outside o_valid)
//   min_out    smaller operand (b when the operands are equal)  [COMPARATOR_MINMAX_EN]
//   max_out    larger operand                                   [COMPARATOR_MINMAX_EN]

module comparator_multicycle #(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         is_signed,
  output logic         o_valid,
  input  logic         o_ready,
  output logic         lt,
  output logic         eq,
  output logic         le
`ifdef COMPARATOR_MINMAX_EN
  ,
  output logic [N-1:0] min_out,
  output logic [N-1:0] max_out
`endif
);

  localparam int NCHUNK = N / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK + 1) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e        state_q;
  logic [N-1:0]  a_sh_q, b_sh_q;
  logic          signed_q;
  logic          carry_q;
  logic          eq_acc_q;
  logic [CW-1:0] cnt_q;
`ifdef COMPARATOR_MINMAX_EN
  logic [N-1:0]  a_q, b_q;
`endif

  // One chunk of a + ~b + carry. The carry seeds to 1, so across all chunks
  // this adder forms a - b.
  logic [CHUNK:0]   sum_d;
  logic [CHUNK-1:0] diff_d;
  logic             cout_d;
  logic             sa_d, sb_d, sd_d;
  logic             lt_last_d, eq_last_d;

  assign sum_d  = {1'b0, a_sh_q[CHUNK-1:0]} + {1'b0, ~b_sh_q[CHUNK-1:0]}
                + {{CHUNK{1'b0}}, carry_q};
  assign diff_d = sum_d[CHUNK-1:0];
  assign cout_d = sum_d[CHUNK];

  // On the last chunk, the low CHUNK bits of the shift registers hold the
  // operands' MSB chunk, so their top bits are the sign bits.
  assign sa_d = a_sh_q[CHUNK-1];
  assign sb_d = b_sh_q[CHUNK-1];
  assign sd_d = diff_d[CHUNK-1];

  // Signed: difference sign corrected for overflow (overflow occurs only when
  // the operand signs differ and the result sign differs from a's sign).
  // Unsigned: no carry out of the subtraction means a borrow, i.e. a < b.
  assign lt_last_d = signed_q ? (sd_d ^ ((sa_d != sb_d) & (sd_d != sa_d))) : ~cout_d;
  assign eq_last_d = eq_acc_q & (diff_d == '0);

  assign i_ready = (state_q == IDLE) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      o_valid  <= 1'b0;
      lt       <= 1'b0;
      eq       <= 1'b0;
      le       <= 1'b0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      eq_acc_q <= 1'b0;
      signed_q <= 1'b0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
`ifdef COMPARATOR_MINMAX_EN
      a_q      <= '0;
      b_q      <= '0;
      min_out  <= '0;
      max_out  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            a_sh_q   <= a;
            b_sh_q   <= b;
            signed_q <= is_signed;
            carry_q  <= 1'b1;
            eq_acc_q <= 1'b1;
            cnt_q    <= '0;
`ifdef COMPARATOR_MINMAX_EN
            a_q      <= a;
            b_q      <= b;
`endif
            state_q  <= RUN;
          end
        end

        RUN: begin
          carry_q  <= cout_d;
          eq_acc_q <= eq_last_d;
          a_sh_q   <= a_sh_q >> CHUNK;
          b_sh_q   <= b_sh_q >> CHUNK;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            lt      <= lt_last_d;
            eq      <= eq_last_d;
            le      <= lt_last_d | eq_last_d;
            o_valid <= 1'b1;
`ifdef COMPARATOR_MINMAX_EN
            min_out <= lt_last_d ? a_q : b_q;
            max_out <= lt_last_d ? b_q : a_q;
`endif
            state_q <= DONE;
          end
        end

        DONE: begin
          if (o_ready) begin
            o_valid <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_multicycle.sv
// Testbench for comparator_multicycle. Three instances share the operand bus:
// CHUNK=1, CHUNK=8 (directed tests) and CHUNK=32. Expected flags come from
// plain signed/unsigned '<' and '=='.

module tb_comparator_multicycle;

  localparam int N = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [N-1:0] a, b;
  logic         s;
  logic         o_ready;
  logic [2:0]   iv, ir, ov, ltv, eqv, lev;
`ifdef COMPARATOR_MINMAX_EN
  logic [2:0][N-1:0] mnv, mxv;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  comparator_multicycle #(.N(N), .CHUNK(1)) u_c1 (
    .clk(clk), .rst(rst), .i_valid(iv[0]), .i_ready(ir[0]), .a(a), .b(b),
    .is_signed(s), .o_valid(ov[0]), .o_ready(o_ready),
    .lt(ltv[0]), .eq(eqv[0]), .le(lev[0])
`ifdef COMPARATOR_MINMAX_EN
    , .min_out(mnv[0]), .max_out(mxv[0])
`endif
  );

  comparator_multicycle #(.N(N), .CHUNK(8)) u_c8 (
    .clk(clk), .rst(rst), .i_valid(iv[1]), .i_ready(ir[1]), .a(a), .b(b),
    .is_signed(s), .o_valid(ov[1]), .o_ready(o_ready),
    .lt(ltv[1]), .eq(eqv[1]), .le(lev[1])
`ifdef COMPARATOR_MINMAX_EN
    , .min_out(mnv[1]), .max_out(mxv[1])
`endif
  );

  comparator_multicycle #(.N(N), .CHUNK(32)) u_c32 (
    .clk(clk), .rst(rst), .i_valid(iv[2]), .i_ready(ir[2]), .a(a), .b(b),
    .is_signed(s), .o_valid(ov[2]), .o_ready(o_ready),
    .lt(ltv[2]), .eq(eqv[2]), .le(lev[2])
`ifdef COMPARATOR_MINMAX_EN
    , .min_out(mnv[2]), .max_out(mxv[2])
`endif
  );

  // Reference: {lt, eq, le} straight from the comparison operators.
  function automatic logic [2:0] ref_flags(input logic [N-1:0] x, input logic [N-1:0] y,
                                           input logic sg);
    logic l, e;
    l = sg ? ($signed(x) < $signed(y)) : (x < y);
    e = (x == y);
    return {l, e, l | e};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic release_result();
    o_ready = 1'b1;
    step();
    o_ready = 1'b0;
  endtask

  // Present one transaction to the CHUNK=8 instance and wait (bounded) for
  // o_valid. lat = edges after the accepting edge; 64 means timed out.
  task automatic do_cmp8(input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                         input logic ts, output int lat);
    a = ta; b = tb_v; s = ts; iv[1] = 1'b1;
    n_checks++;
    if (ir[1] !== 1'b1) $display("FAIL accept_ready: i_ready=%b required 1", ir[1]);
    else n_pass++;
    step();
    iv[1] = 1'b0;
    lat = 0;
    while (ov[1] !== 1'b1 && lat < 64) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; iv = '0; o_ready = 1'b0; a = '0; b = '0; s = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    n_checks++;
    if (ov !== 3'b000) $display("FAIL reset_o_valid: got %b required 000", ov);
    else n_pass++;
    n_checks++;
    if ({ltv, eqv, lev} !== 9'b0) $display("FAIL reset_flags: lt=%b eq=%b le=%b required all 0", ltv, eqv, lev);
    else n_pass++;
    n_checks++;
    if (ir !== 3'b111) $display("FAIL reset_i_ready: got %b required 111", ir);
    else n_pass++;
  endtask

  // Run one directed compare on CHUNK=8 and check latency and flags.
  task automatic directed(input string name, input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                          input logic ts, input logic [2:0] exp_f);
    int lat;
    do_cmp8(ta, tb_v, ts, lat);
    n_checks++;
    if (lat != 4) $display("FAIL %s_latency: got %0d edges required 4", name, lat);
    else n_pass++;
    n_checks++;
    if ({ltv[1], eqv[1], lev[1]} !== exp_f)
      $display("FAIL %s_flags: lt/eq/le=%b required %b", name, {ltv[1], eqv[1], lev[1]}, exp_f);
    else n_pass++;
    release_result();
  endtask

  task automatic test_signed();
    directed("min_vs_max_signed",   32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'b101);
    directed("min_vs_max_unsigned", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 3'b000);
    directed("zero_vs_m1_signed",   32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 3'b000);
    directed("zero_vs_ones_unsigned", 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 3'b101);
  endtask

  task automatic test_equal();
    directed("ones_eq_signed",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 3'b011);
    directed("ones_eq_unsigned", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 3'b011);
    directed("eq_accumulate",    32'd5, 32'd5 + 32'h0100_0000, 1'b0, 3'b101);
  endtask

  task automatic test_backpressure();
    int lat;
    do_cmp8(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, lat);
    n_checks++;
    if (lat != 4) $display("FAIL bp_latency: got %0d edges required 4", lat);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if ({ov[1], ltv[1], eqv[1], lev[1], ir[1]} !== 5'b1_101_0)
        $display("FAIL bp_hold cycle %0d: o_valid=%b flags=%b i_ready=%b required 1 101 0",
                 i, ov[1], {ltv[1], eqv[1], lev[1]}, ir[1]);
      else n_pass++;
    end
    o_ready = 1'b1;
    step();
    o_ready = 1'b0;
    n_checks++;
    if ({ov[1], ir[1]} !== 2'b01)
      $display("FAIL bp_release: o_valid=%b i_ready=%b required 0 1", ov[1], ir[1]);
    else n_pass++;
  endtask

  // o_ready already high before the result: o_valid lasts exactly one cycle.
  task automatic test_ready_early();
    int lat;
    o_ready = 1'b1;
    do_cmp8(32'd7, 32'd9, 1'b0, lat);
    n_checks++;
    if (lat != 4 || {ltv[1], eqv[1], lev[1]} !== 3'b101)
      $display("FAIL ready_early_result: latency=%0d flags=%b required 4 101", lat, {ltv[1], eqv[1], lev[1]});
    else n_pass++;
    step();
    o_ready = 1'b0;
    n_checks++;
    if ({ov[1], ir[1]} !== 2'b01)
      $display("FAIL ready_early_drop: o_valid=%b i_ready=%b required 0 1", ov[1], ir[1]);
    else n_pass++;
  endtask

  task automatic test_abort();
    int seen;
    a = 32'd1; b = 32'd2; s = 1'b1; iv[1] = 1'b1;
    step();
    iv[1] = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({ov[1], ir[1]} !== 2'b01)
      $display("FAIL abort_idle: o_valid=%b i_ready=%b required 0 1", ov[1], ir[1]);
    else n_pass++;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (ov[1] === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) $display("FAIL abort_no_valid: o_valid high %0d cycles required 0", seen);
    else n_pass++;
    directed("after_abort", 32'hFFFF_FFFD, 32'hFFFF_FFF9, 1'b1, 3'b000);
  endtask

  task automatic test_sweep(input int iters);
    logic [N-1:0] pool [5];
    int           lat [3];
    int           exp_lat [3];
    int           cyc, r;
    logic [2:0]   exp_f;
    pool[0] = 32'h0000_0000; pool[1] = 32'hFFFF_FFFF; pool[2] = 32'h8000_0000;
    pool[3] = 32'h7FFF_FFFF; pool[4] = 32'h0000_0001;
    exp_lat[0] = 32; exp_lat[1] = 4; exp_lat[2] = 1;
    for (int it = 0; it < iters; it++) begin
      r = $urandom_range(0, 7);
      a = (r == 0) ? pool[$urandom_range(0, 4)] : $urandom;
      b = (r == 1) ? a : ((r == 2) ? pool[$urandom_range(0, 4)] : $urandom);
      if (r == 3) b = a ^ (32'h1 << $urandom_range(0, 31));
      s = 1'($urandom_range(0, 1));
      exp_f = ref_flags(a, b, s);
      iv = 3'b111;
      step();
      iv = 3'b000;
      for (int k = 0; k < 3; k++) lat[k] = -1;
      cyc = 0;
      while (ov !== 3'b111 && cyc < 100) begin
        step();
        cyc++;
        for (int k = 0; k < 3; k++)
          if (ov[k] === 1'b1 && lat[k] < 0) lat[k] = cyc;
      end
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (lat[k] != exp_lat[k])
          $display("FAIL sweep_latency inst %0d iter %0d: got %0d required %0d", k, it, lat[k], exp_lat[k]);
        else n_pass++;
        n_checks++;
        if ({ltv[k], eqv[k], lev[k]} !== exp_f)
          $display("FAIL sweep_flags inst %0d a=%h b=%h signed=%b: lt/eq/le=%b required %b",
                   k, a, b, s, {ltv[k], eqv[k], lev[k]}, exp_f);
        else n_pass++;
`ifdef COMPARATOR_MINMAX_EN
        n_checks++;
        if (mnv[k] !== (exp_f[2] ? a : b) || mxv[k] !== (exp_f[2] ? b : a))
          $display("FAIL sweep_minmax inst %0d a=%h b=%h: min=%h max=%h required %h %h",
                   k, a, b, mnv[k], mxv[k], exp_f[2] ? a : b, exp_f[2] ? b : a);
        else n_pass++;
`endif
      end
      release_result();
    end
  endtask

  initial begin
    test_reset();
    test_signed();
    test_equal();
    test_backpressure();
    test_ready_early();
    test_abort();
    test_sweep(300);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
